// File: rtl/tdc_capture_ctrl.sv
// tdc_capture_ctrl: launches one TDC delay line, captures and synchronises its taps,
// thermometer-encodes each sample and sums 2^AVG_LOG2 samples per measurement.
// Optional macro TDC_BUBBLE_FILTER_EN adds a 3-tap majority bubble filter ahead of the encoder.
module tdc_capture_ctrl #(
  parameter int N           = 64,
  parameter int SYNC_STAGES = 2,
  parameter int AVG_LOG2    = 2,
  localparam int OUT_W      = $clog2(N + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      arm_i,
  input  logic [N-1:0]              taps_i,
  output logic                      launch_o,
  output logic                      busy_o,
  output logic [OUT_W+AVG_LOG2-1:0] sum_o,
  output logic                      valid_o,
  output logic                      overflow_o
);

  localparam int SUM_W  = OUT_W + AVG_LOG2;
  localparam int CNT_W  = AVG_LOG2 + 1;
  localparam int SCNT_W = (SYNC_STAGES > 1) ? $clog2(SYNC_STAGES) : 1;
  localparam logic [CNT_W-1:0]  LAST_SAMPLE = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [SCNT_W-1:0] LAST_SYNC   = SCNT_W'(SYNC_STAGES - 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, SYNC, ACC, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [SCNT_W-1:0]  scnt_q;
  logic [SUM_W-1:0]   acc_q, acc_next;
  logic               ovf_q, ovf_next;
  logic [N-1:0]       cap_q;
  logic [N-1:0]       sync_q [SYNC_STAGES];
  logic [N-1:0]       enc_in;
  logic [OUT_W-1:0]   code;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode plus the state-derived status outputs.
  always_comb begin
    state_d = state_q;
    busy_o  = (state_q != IDLE);
    valid_o = (state_q == DONE);
    case (state_q)
      IDLE:    if (arm_i) state_d = LAUNCH;
      LAUNCH:  state_d = SYNC;
      SYNC:    if (scnt_q == LAST_SYNC) state_d = ACC;
      ACC:     state_d = (cnt_q == LAST_SAMPLE) ? DONE : LAUNCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Launch edge is registered so the delay-line input never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) launch_o <= 1'b0;
    else        launch_o <= (state_d == LAUNCH);
  end

  // Capture flop closes with the LAUNCH cycle; the chain behind it shifts every cycle
  // so the last stage holds that capture exactly when the FSM reaches ACC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      if (state_q == LAUNCH) cap_q <= taps_i;
      sync_q[0] <= cap_q;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

`ifdef TDC_BUBBLE_FILTER_EN
  // Pad below with 1 and above with 0 so the line ends behave like a clean thermometer.
  logic [N+1:0] ext;
  assign ext = {1'b0, sync_q[SYNC_STAGES-1], 1'b1};

  // Majority of each tap and its two neighbours removes isolated bubbles.
  always_comb begin
    enc_in = '0;
    for (int i = 0; i < N; i++)
      enc_in[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
  end
`else
  assign enc_in = sync_q[SYNC_STAGES-1];
`endif

  // Code is one above the highest set tap, zero when the line is empty.
  always_comb begin
    code = '0;
    for (int i = 0; i < N; i++)
      if (enc_in[i]) code = OUT_W'(i + 1);
  end

  assign acc_next = acc_q + SUM_W'(code);
  assign ovf_next = ovf_q | enc_in[N-1];

  // Sample counting and accumulation; the result registers load on the final ACC so
  // they are already new during the DONE strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      scnt_q     <= '0;
      sum_o      <= '0;
      overflow_o <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (arm_i) begin
          acc_q <= '0;
          ovf_q <= 1'b0;
          cnt_q <= '0;
        end
        LAUNCH: scnt_q <= '0;
        SYNC:   scnt_q <= scnt_q + 1'b1;
        ACC: begin
          acc_q <= acc_next;
          ovf_q <= ovf_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_SAMPLE) begin
            sum_o      <= acc_next;
            overflow_o <= ovf_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_capture_ctrl.sv
// Bench for tdc_capture_ctrl: directed and random stimulus, timeline-based reference model
// on the rising edge, scoreboard monitor on the falling edge.
module tb_tdc_capture_ctrl;

  localparam int N           = 64;
  localparam int SYNC_STAGES = 2;
  localparam int AVG_LOG2    = 2;
  localparam int NSAMP       = 1 << AVG_LOG2;
  localparam int PER         = SYNC_STAGES + 2;
  localparam int LAT         = NSAMP * PER;
  localparam int SUM_W       = $clog2(N + 1) + AVG_LOG2;
`ifdef TDC_BUBBLE_FILTER_EN
  localparam int BUBBLE_SUM  = 32;
`else
  localparam int BUBBLE_SUM  = 68;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             arm_i = 1'b0;
  logic [N-1:0]     taps_i = '0;
  logic             launch_o, busy_o, valid_o, overflow_o;
  logic [SUM_W-1:0] sum_o;

  always #5 clk = ~clk;

  tdc_capture_ctrl #(.N(N), .SYNC_STAGES(SYNC_STAGES), .AVG_LOG2(AVG_LOG2)) dut (
    .clk(clk), .rst_n(rst_n), .arm_i(arm_i), .taps_i(taps_i),
    .launch_o(launch_o), .busy_o(busy_o), .sum_o(sum_o),
    .valid_o(valid_o), .overflow_o(overflow_o)
  );

  typedef struct { int sum; bit ovf; } exp_t;
  exp_t exp_q[$];
  exp_t dir_q[$];

  int edge_cnt = 0, arm_edge = 0, busy_until = -1, m_sum = 0, m_n = 0;
  bit m_ovf = 1'b0;
  bit exp_busy = 1'b0, exp_launch = 1'b0, exp_valid = 1'b0;
  int n_cmp = 0, n_fail = 0;
  bit finishing = 1'b0, final_done = 1'b0;

  // Timeline: a measurement accepted at edge A occupies the cycles after edges A..A+LAT,
  // launching after A, A+PER, ... and reporting in the cycle after A+LAT.
  function automatic bit busy_at(input int e);
    return (e >= arm_edge) && (e <= busy_until);
  endfunction

  function automatic bit launch_at(input int e);
    int rel;
    if (!busy_at(e)) return 1'b0;
    rel = e - arm_edge;
    return (rel < LAT) && (rel % PER == 0);
  endfunction

  function automatic int enc(input logic [N-1:0] t);
    for (int i = N - 1; i >= 0; i--) if (t[i]) return i + 1;
    return 0;
  endfunction

  function automatic logic [N-1:0] shape(input logic [N-1:0] t);
`ifdef TDC_BUBBLE_FILTER_EN
    logic [N-1:0] f;
    int lo, hi;
    for (int i = 0; i < N; i++) begin
      if (i == 0) lo = 1; else lo = int'(t[i-1]);
      if (i == N - 1) hi = 0; else hi = int'(t[i+1]);
      f[i] = (lo + int'(t[i]) + hi) >= 2;
    end
    return f;
`else
    return t;
`endif
  endfunction

  function automatic logic [N-1:0] rand_taps();
    logic [N-1:0] v;
    int len;
    case ($urandom_range(0, 3))
      0: v = '0;
      1: begin
        len = $urandom_range(0, N);
        v = '0;
        for (int i = 0; i < len; i++) v[i] = 1'b1;
        if ($urandom_range(0, 1) == 1) v[$urandom_range(0, N - 1)] ^= 1'b1;
      end
      2: v = {$urandom, $urandom};
      default: v = '1;
    endcase
    return v;
  endfunction

  // Reference model: tracks the measurement timeline and samples taps at each launch close.
  always @(posedge clk) begin : model
    int e;
    bit launch_before, idle_before;
    logic [N-1:0] s;
    edge_cnt++;
    e = edge_cnt;
    if (!rst_n) begin
      busy_until = -1;
      arm_edge   = 0;
      m_n        = 0;
      exp_q.delete();
    end else begin
      launch_before = launch_at(e - 1);
      idle_before   = !busy_at(e - 1);
      if (launch_before) begin
        s = shape(taps_i);
        m_sum += enc(s);
        m_ovf |= s[N-1];
        m_n++;
        if (m_n == NSAMP) exp_q.push_back(exp_t'{m_sum, m_ovf});
      end
      if (arm_i && idle_before) begin
        arm_edge   = e;
        busy_until = e + LAT;
        m_sum = 0;
        m_ovf = 1'b0;
        m_n   = 0;
      end
    end
    exp_busy   = rst_n && busy_at(e);
    exp_launch = rst_n && launch_at(e);
    exp_valid  = rst_n && (e == busy_until);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: compares every cycle and pops expectations whenever valid_o strobes.
  always @(negedge clk) begin : monitor
    exp_t x;
    if (!rst_n) begin
      chk("reset_launch", 64'(launch_o), 64'd0);
      chk("reset_busy", 64'(busy_o), 64'd0);
      chk("reset_valid", 64'(valid_o), 64'd0);
      chk("reset_overflow", 64'(overflow_o), 64'd0);
      chk("reset_sum", 64'(sum_o), 64'd0);
    end else begin
      chk("busy", 64'(busy_o), 64'(exp_busy));
      chk("launch", 64'(launch_o), 64'(exp_launch));
      chk("valid", 64'(valid_o), 64'(exp_valid));
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_valid: got valid_o=1, expected no result pending (t=%0t)", $time);
        end else begin
          x = exp_q.pop_front();
          chk("sum", 64'(sum_o), 64'(x.sum));
          chk("overflow", 64'(overflow_o), 64'(x.ovf));
        end
        if (dir_q.size() > 0) begin
          x = dir_q.pop_front();
          chk("directed_sum", 64'(sum_o), 64'(x.sum));
          chk("directed_overflow", 64'(overflow_o), 64'(x.ovf));
        end
      end
    end
    if (finishing && !final_done) begin
      chk("results_outstanding", 64'(exp_q.size()), 64'd0);
      chk("directed_outstanding", 64'(dir_q.size()), 64'd0);
      final_done = 1'b1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic arm_pulse();
    arm_i = 1'b1;
    step(1);
    arm_i = 1'b0;
  endtask

  initial begin
    step(3);
    rst_n = 1'b1;
    step(2);

    // Clean thermometer of 8 taps: code 8 per sample.
    taps_i = 64'h0000_0000_0000_00FF;
    dir_q.push_back(exp_t'{32, 1'b0});
    arm_pulse();
    step(25);

    // Full line: every sample overflows.
    taps_i = '1;
    dir_q.push_back(exp_t'{256, 1'b1});
    arm_pulse();
    step(25);

    // Empty line clears both sum and the sticky flag.
    taps_i = '0;
    dir_q.push_back(exp_t'{0, 1'b0});
    arm_pulse();
    step(25);

    // Isolated bubble above the thermometer edge.
    taps_i = 64'h0000_0000_0001_00FF;
    dir_q.push_back(exp_t'{BUBBLE_SUM, 1'b0});
    arm_pulse();
    step(25);

    // Arm chatter while busy must not start or queue anything.
    taps_i = 64'h0000_0000_0000_000F;
    dir_q.push_back(exp_t'{16, 1'b0});
    arm_pulse();
    repeat (12) begin
      step(1);
      arm_i = 1'($urandom_range(0, 1));
    end
    arm_i = 1'b0;
    step(15);

    // Reset during SYNC with a full line: measurement is discarded.
    taps_i = '1;
    arm_pulse();
    step(1);
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(30);

    // Random taps every cycle, arm mostly held high for back-to-back measurements.
    repeat (800) begin
      taps_i = rand_taps();
      arm_i  = ($urandom_range(0, 3) != 0);
      step(1);
    end
    arm_i = 1'b0;
    step(30);

    finishing = 1'b1;
    step(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tdc_capture_ctrl.md
Name: tdc_capture_ctrl

Overview:
- Sequencing and encoding controller for one TDC delay line.
- Issues the launch edge into the line (top level: launch_o -> delay_line.in).
- Samples the tap vector (delay_line.dl_out -> taps_i) one clock later and passes it through a synchroniser chain.
- Thermometer-encodes each sample and accumulates 2^AVG_LOG2 samples per measurement; reports the sum with a one-cycle valid strobe and a sticky overflow flag.

Parameters:
- N, 64, number of delay-line taps (>=4).
- SYNC_STAGES, 2, register stages after the capture flop (>=1).
- AVG_LOG2, 2, log2 of samples accumulated per measurement (0..6).
- OUT_W, $clog2(N+1), derived width of one encoded sample (not overridden).

Ports:
- clk  in  1  system clock; launch, capture and FSM all on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- arm_i  in  1  start one measurement; sampled only in IDLE.
- taps_i  in  N  raw delay-line tap outputs, asynchronous to clk.
- launch_o  out  1  drives delay-line input.
- busy_o  out  1  high whenever FSM is not IDLE.
- sum_o  out  OUT_W+AVG_LOG2  accumulated code of last measurement.
- valid_o  out  1  one-cycle strobe, sum_o/overflow_o new.
- overflow_o  out  1  some sample in the batch had taps_i[N-1]=1.

Behaviour:
- Reset (async assert, sync release):
  - FSM=IDLE.
  - launch_o, busy_o, valid_o, overflow_o, sum_o, accumulator, sample counter and capture/sync registers all 0.
  - Reset mid-measurement aborts it; no valid_o follows.
- States: IDLE, LAUNCH, SYNC, ACC, DONE.
  - IDLE: launch_o=0. arm_i=1 at edge -> LAUNCH; accumulator, overflow and sample count cleared on that edge.
  - LAUNCH (1 cycle): launch_o=1. At the closing edge, taps_i is captured into the capture flop -> SYNC.
  - SYNC (SYNC_STAGES cycles): launch_o=0 so the line drains to 0. Capture value shifts through the sync chain -> ACC.
  - ACC (1 cycle): encode the sync-chain output, add it to the accumulator, OR taps[N-1] into overflow, increment sample count. Then if count == 2^AVG_LOG2 -> DONE, else -> LAUNCH.
  - DONE (1 cycle): sum_o <= accumulator, overflow_o <= overflow accumulation, valid_o=1 -> IDLE.
- Encoding: code = (index of highest set tap)+1; 0 if no tap set; N if taps[N-1]=1. The code range 0..N fits OUT_W bits.
- Accumulator width OUT_W+AVG_LOG2; it cannot wrap (max N*2^AVG_LOG2).
- sum_o and overflow_o hold until the next DONE. valid_o is high only in DONE.
- Latency: arm_i accepted at edge k -> valid_o high during cycle k + 2^AVG_LOG2*(SYNC_STAGES+2) + 1. Defaults give 17.
- arm_i while busy_o=1 is ignored, not queued. arm_i held high starts a new measurement the cycle after DONE returns to IDLE.
- launch_o is a registered output, glitch-free.

Optional Feature:
- Macro TDC_BUBBLE_FILTER_EN.
- Defined: 3-tap majority filter on the sync-chain output before encoding.
  - f[i] = maj(t[i-1], t[i], t[i+1]), with t[-1]=1 and t[N]=0.
  - Purely combinational in the ACC cycle; latency unchanged.
  - Overflow uses the filtered f[N-1].
- Undefined: raw taps are encoded directly and overflow uses raw taps[N-1].

Test Plan:
- Reset: drive rst_n=0 mid-SYNC with taps_i=all ones -> all outputs 0 asynchronously; no valid_o after release; busy_o=0.
- Single measurement, defaults, taps_i=64'h0000_0000_0000_00FF held -> valid_o exactly 17 cycles after arm edge; sum_o=32 (4x8); overflow_o=0; launch_o high 4 times, 1 cycle each.
- Overflow: taps_i=all ones -> sum_o=256; overflow_o=1. Next batch with taps_i=0 -> sum_o=0, overflow_o=0.
- Varying taps, AVG_LOG2=0: taps 8'h0F per launch capture -> sum_o=4 each measurement; arm_i held high -> back-to-back measurements, one idle cycle between valid_o and the next launch.
- Bubble, taps_i=64'h0000_0000_0001_00FF: without macro -> per-sample code 17, sum_o=68; with TDC_BUBBLE_FILTER_EN -> code 8, sum_o=32.
- arm_i pulses while busy_o=1 -> ignored: exactly one valid_o per accepted arm; sum_o unaffected.
